// File: rtl/riscv_hwloop_pkg.sv
// Shared constants for the RI5CY hardware-loop register file: default loop count,
// CSR read-field encodings and write-enable bit positions.
package riscv_hwloop_pkg;

  localparam int unsigned N_HWLP_DEFAULT = 2;

  typedef enum logic [1:0] {
    HWLP_FIELD_START = 2'd0,
    HWLP_FIELD_END   = 2'd1,
    HWLP_FIELD_CNT   = 2'd2,
    HWLP_FIELD_NONE  = 2'd3
  } hwlp_field_e;

  localparam int unsigned HWLP_WE_START = 0;
  localparam int unsigned HWLP_WE_END   = 1;
  localparam int unsigned HWLP_WE_CNT   = 2;

endpackage

// File: rtl/riscv_hwloop_entry.sv
// One hardware-loop register set: start, end and iteration counter with a
// floor-at-zero decrement and an active flag.
module riscv_hwloop_entry
  import riscv_hwloop_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  we,
  input  logic [31:0] start_data,
  input  logic [31:0] end_data,
  input  logic [31:0] cnt_data,
  input  logic        dec,
  output logic [31:0] start_addr,
  output logic [31:0] end_addr,
  output logic [31:0] counter,
  output logic        active
);

  logic [31:0] start_q;
  logic [31:0] end_q;
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (we[HWLP_WE_START]) start_q <= start_data;
      if (we[HWLP_WE_END])   end_q   <= end_data;
      // A counter write overrides a same-cycle decrement.
      if (we[HWLP_WE_CNT]) begin
        cnt_q <= cnt_data;
      end else if (dec && (cnt_q != 32'd0)) begin
        cnt_q <= cnt_q - 32'd1;
      end
    end
  end

  assign start_addr = start_q;
  assign end_addr   = end_q;
  assign counter    = cnt_q;
  assign active     = (cnt_q != 32'd0);

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: N_LOOPS register sets, priority selection of the
// innermost active loop, write/decrement steering and a CSR read port.
module riscv_hwloop_regs
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_LOOPS = N_HWLP_DEFAULT,
  localparam int unsigned IdxW = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          hwlp_we_i,
  input  logic [IdxW-1:0]     hwlp_regid_i,
  input  logic [31:0]         hwlp_start_data_i,
  input  logic [31:0]         hwlp_end_data_i,
  input  logic [31:0]         hwlp_cnt_data_i,
  input  logic                hwlp_dec_cnt_i,
  input  logic [IdxW-1:0]     csr_regid_i,
  input  logic [1:0]          csr_field_i,
  output logic [31:0]         csr_rdata_o,
  output logic [31:0]         hwlp_start_addr_o,
  output logic [31:0]         hwlp_end_addr_o,
  output logic [31:0]         hwlp_counter_o,
  output logic [N_LOOPS-1:0]  hwlp_active_o
);

  localparam logic [IdxW:0] NLoopsW = (IdxW + 1)'(N_LOOPS);

  logic [31:0]       loop_start [N_LOOPS];
  logic [31:0]       loop_end   [N_LOOPS];
  logic [31:0]       loop_cnt   [N_LOOPS];
  logic [N_LOOPS-1:0] active;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;

  // Lowest index wins: scan downward so the innermost active loop is last written.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(N_LOOPS) - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  for (genvar g = 0; g < N_LOOPS; g++) begin : g_loop
    logic [2:0] we_loop;
    logic       dec_loop;

    assign we_loop  = (hwlp_regid_i == IdxW'(g)) ? hwlp_we_i : 3'b000;
    assign dec_loop = hwlp_dec_cnt_i & sel_valid & (sel_idx == IdxW'(g));

    riscv_hwloop_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .we         (we_loop),
      .start_data (hwlp_start_data_i),
      .end_data   (hwlp_end_data_i),
      .cnt_data   (hwlp_cnt_data_i),
      .dec        (dec_loop),
      .start_addr (loop_start[g]),
      .end_addr   (loop_end[g]),
      .counter    (loop_cnt[g]),
      .active     (active[g])
    );
  end

  // Idle outputs are all zero so the controller never sees a stale start/end.
  assign hwlp_start_addr_o = sel_valid ? loop_start[sel_idx] : 32'd0;
  assign hwlp_end_addr_o   = sel_valid ? loop_end[sel_idx]   : 32'd0;
  assign hwlp_counter_o    = sel_valid ? loop_cnt[sel_idx]   : 32'd0;
  assign hwlp_active_o     = active;

  always_comb begin
    csr_rdata_o = 32'd0;
    if ({1'b0, csr_regid_i} < NLoopsW) begin
      case (csr_field_i)
        HWLP_FIELD_START: csr_rdata_o = loop_start[csr_regid_i];
        HWLP_FIELD_END:   csr_rdata_o = loop_end[csr_regid_i];
        HWLP_FIELD_CNT:   csr_rdata_o = loop_cnt[csr_regid_i];
        default:          csr_rdata_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Scoreboard bench for riscv_hwloop_regs: stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_riscv_hwloop_regs;

  logic        clk;
  logic        rst;
  logic [2:0]  hwlp_we_i;
  logic [0:0]  hwlp_regid_i;
  logic [31:0] hwlp_start_data_i;
  logic [31:0] hwlp_end_data_i;
  logic [31:0] hwlp_cnt_data_i;
  logic        hwlp_dec_cnt_i;
  logic [0:0]  csr_regid_i;
  logic [1:0]  csr_field_i;
  logic [31:0] csr_rdata_o;
  logic [31:0] hwlp_start_addr_o;
  logic [31:0] hwlp_end_addr_o;
  logic [31:0] hwlp_counter_o;
  logic [1:0]  hwlp_active_o;

  riscv_hwloop_regs #(.N_LOOPS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_we_i         (hwlp_we_i),
    .hwlp_regid_i      (hwlp_regid_i),
    .hwlp_start_data_i (hwlp_start_data_i),
    .hwlp_end_data_i   (hwlp_end_data_i),
    .hwlp_cnt_data_i   (hwlp_cnt_data_i),
    .hwlp_dec_cnt_i    (hwlp_dec_cnt_i),
    .csr_regid_i       (csr_regid_i),
    .csr_field_i       (csr_field_i),
    .csr_rdata_o       (csr_rdata_o),
    .hwlp_start_addr_o (hwlp_start_addr_o),
    .hwlp_end_addr_o   (hwlp_end_addr_o),
    .hwlp_counter_o    (hwlp_counter_o),
    .hwlp_active_o     (hwlp_active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] c;
    logic [1:0]  a;
    logic [31:0] r;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic void push(input string nm, input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] c, input logic [1:0] a, input logic [31:0] r);
    exp_t x;
    x.s = s; x.e = e; x.c = c; x.a = a; x.r = r;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endfunction

  // Apply one cycle of stimulus, then select the CSR read and record the expected state.
  task automatic step(input logic [2:0] we, input logic [0:0] rid, input logic [31:0] s,
                      input logic [31:0] e, input logic [31:0] c, input logic dec,
                      input logic [0:0] cid, input logic [1:0] cf, input string nm,
                      input logic [31:0] xs, input logic [31:0] xe, input logic [31:0] xc,
                      input logic [1:0] xa, input logic [31:0] xr);
    hwlp_we_i         = we;
    hwlp_regid_i      = rid;
    hwlp_start_data_i = s;
    hwlp_end_data_i   = e;
    hwlp_cnt_data_i   = c;
    hwlp_dec_cnt_i    = dec;
    @(posedge clk);
    #1;
    hwlp_we_i      = 3'b000;
    hwlp_dec_cnt_i = 1'b0;
    csr_regid_i    = cid;
    csr_field_i    = cf;
    push(nm, xs, xe, xc, xa, xr);
  endtask

  initial begin : monitor
    exp_t  ex;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if ({hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_active_o, csr_rdata_o}
            !== {ex.s, ex.e, ex.c, ex.a, ex.r}) begin
          n_err++;
          $display("FAIL %s: got start=%h end=%h cnt=%h act=%b csr=%h, expected start=%h end=%h cnt=%h act=%b csr=%h",
                   nm, hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_active_o,
                   csr_rdata_o, ex.s, ex.e, ex.c, ex.a, ex.r);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    hwlp_we_i = 3'b000; hwlp_regid_i = 1'b0;
    hwlp_start_data_i = '0; hwlp_end_data_i = '0; hwlp_cnt_data_i = '0;
    hwlp_dec_cnt_i = 1'b0; csr_regid_i = 1'b0; csr_field_i = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    push("reset", 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single loop: setup then run down to zero.
    step(3'b111, 1'b0, 32'h100, 32'h120, 32'd3, 1'b0, 1'b0, 2'd2, "setup0",
         32'h100, 32'h120, 32'd3, 2'b01, 32'd3);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 2'd2, "dec1",
         32'h100, 32'h120, 32'd2, 2'b01, 32'd2);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 2'd2, "dec2",
         32'h100, 32'h120, 32'd1, 2'b01, 32'd1);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 2'd0, "dec3_idle_out",
         32'h0, 32'h0, 32'h0, 2'b00, 32'h100);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 2'd2, "dec_noactive0",
         32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b1, 2'd2, "dec_noactive1",
         32'h0, 32'h0, 32'h0, 2'b00, 32'h0);

    // Nested loops: inner hands over to outer.
    step(3'b111, 1'b1, 32'h80, 32'h140, 32'd2, 1'b0, 1'b1, 2'd1, "setup1",
         32'h80, 32'h140, 32'd2, 2'b10, 32'h140);
    step(3'b111, 1'b0, 32'h100, 32'h120, 32'd1, 1'b0, 1'b0, 2'd2, "setup0_nested",
         32'h100, 32'h120, 32'd1, 2'b11, 32'd1);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b1, 2'd2, "handover",
         32'h80, 32'h140, 32'd2, 2'b10, 32'd2);
    step(3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 2'd2, "dec_outer",
         32'h80, 32'h140, 32'd1, 2'b10, 32'd0);

    // Write/decrement interaction.
    step(3'b100, 1'b0, 0, 0, 32'd2, 1'b0, 1'b0, 2'd3, "cnt_only_field3",
         32'h100, 32'h120, 32'd2, 2'b11, 32'd0);
    step(3'b100, 1'b0, 0, 0, 32'd5, 1'b1, 1'b0, 2'd2, "write_wins",
         32'h100, 32'h120, 32'd5, 2'b11, 32'd5);
    step(3'b100, 1'b1, 0, 0, 32'd9, 1'b1, 1'b1, 2'd2, "dec_other_write",
         32'h100, 32'h120, 32'd4, 2'b11, 32'd9);
    step(3'b001, 1'b0, 32'h200, 0, 0, 1'b1, 1'b0, 2'd0, "dec_start_write",
         32'h200, 32'h120, 32'd3, 2'b11, 32'h200);
    step(3'b100, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0, 2'd2, "write_cnt0",
         32'h80, 32'h140, 32'd9, 2'b10, 32'd0);
    step(3'b100, 1'b0, 0, 0, 32'd7, 1'b0, 1'b0, 2'd1, "write_cnt7",
         32'h200, 32'h120, 32'd7, 2'b11, 32'h120);

    // Asynchronous reset between edges, with a decrement pending.
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    hwlp_dec_cnt_i = 1'b1;
    csr_regid_i = 1'b0;
    csr_field_i = 2'd2;
    push("rst_async", 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    for (int l = 0; l < 2; l++) begin
      for (int f = 0; f < 4; f++) begin
        @(posedge clk);
        #1;
        csr_regid_i = 1'(l);
        csr_field_i = 2'(f);
        push($sformatf("rst_csr_l%0d_f%0d", l, f), 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    hwlp_dec_cnt_i = 1'b0;
    step(3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b1, 2'd0, "post_rst",
         32'h0, 32'h0, 32'h0, 2'b00, 32'h0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_regs.md
# riscv_hwloop_regs

Hardware-loop register file for RI5CY. Holds start address, end address and iteration counter for `N_LOOPS` loops, written by the ID stage (`lp.setup*`, `lp.start/end/count[i]`) and by CSR writes. It also selects the active loop and presents its start, end and counter as single 32-bit values. Sits directly upstream of `riscv_hwloop_controller`, which compares the PC and returns the decrement request.

## Interface
- `N_LOOPS`, default 2: number of loop register sets; loop 0 is the innermost and has highest priority.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hwlp_we_i`  in  3  write enables {counter, end, start}, bits [2:0] = {cnt, end, start}.
- `hwlp_regid_i`  in  $clog2(N_LOOPS)  target loop of the write.
- `hwlp_start_data_i`  in  32  start address write data.
- `hwlp_end_data_i`  in  32  end address write data.
- `hwlp_cnt_data_i`  in  32  counter write data.
- `hwlp_dec_cnt_i`  in  1  decrement request from controller; applies to the currently selected loop.
- `csr_regid_i`  in  $clog2(N_LOOPS)  read-port loop index.
- `csr_field_i`  in  2  read-port field: 0 start, 1 end, 2 counter, 3 reads zero.
- `csr_rdata_o`  out  32  combinational read data.
- `hwlp_start_addr_o`  out  32  start address of selected loop.
- `hwlp_end_addr_o`  out  32  end address of selected loop.
- `hwlp_counter_o`  out  32  counter of selected loop.
- `hwlp_active_o`  out  N_LOOPS  per-loop active flag (counter != 0).

## Operation
- State per loop: start[31:0], end[31:0], cnt[31:0]. Reset clears all of them to 0. After reset every output is 0 and `hwlp_active_o` = 0.
- Write: each `hwlp_we_i` bit independently updates its field of loop `hwlp_regid_i` at the next edge. All three bits together implement `lp.setup` in one cycle.
- Selection (combinational): `sel` = lowest index i with cnt[i] != 0. With no loop active, the outputs drive start = 0, end = 0, counter = 0. That zero counter guarantees the controller never jumps.
- Decrement: when `hwlp_dec_cnt_i` = 1, cnt[sel] <= cnt[sel] - 1 at the next edge.
  - Decrement with no active loop is ignored; the counter never wraps below 0.
- Simultaneous write and decrement:
  - Write to the counter of loop `sel`: the write wins and the decrement is dropped.
  - Write to a different loop, or a write of start/end only: both take effect.
- When cnt[0] reaches 0, selection falls to loop 1 in the same cycle the new value is visible. This is how a finished inner loop hands over to the outer loop.
- Writing counter 0 deactivates a loop immediately (next cycle).
- `csr_rdata_o` reflects register contents, not the selection.
- Reset mid-operation clears all loops asynchronously; no pending decrement survives.

## Timing
- Writes and decrements become visible one cycle after the enabling edge.
- Selected outputs and `csr_rdata_o` are combinational from registers; there is no input-to-output combinational path, except `csr_regid_i`/`csr_field_i` to `csr_rdata_o`.
- `hwlp_dec_cnt_i` from the controller depends only on the registered outputs of this block and the PC, so there is no combinational loop.
- Back-to-back decrements on consecutive cycles are supported: one per cycle.

## Structure
- `riscv_hwloop_pkg`: `N_HWLP_DEFAULT` = 2, the field encodings `HWLP_FIELD_START/END/CNT`, and the `hwlp_we_i` bit positions.
- Sub-module `riscv_hwloop_entry`: one loop's three registers, write enables, decrement-with-floor and active flag. It is instantiated `N_LOOPS` times under a generate loop.
- The top level holds the priority selector, output mux, write/decrement steering and CSR read mux.

## Test plan
- Reset, then write all three fields to loop 0: start = 0x100, end = 0x120, cnt = 3 -> next cycle outputs are 0x100/0x120/3 and `hwlp_active_o` = 2'b01.
- Three consecutive `hwlp_dec_cnt_i` pulses -> counter reads 2, 1, 0. After the third pulse `hwlp_active_o` = 0 and all outputs are 0.
- Loop 1 = {0x80, 0x140, 2} and loop 0 = {0x100, 0x120, 1}:
  - One decrement -> loop 0 goes inactive.
  - The outputs switch to 0x80/0x140/2.
  - The next decrement affects loop 1 only.
- Same cycle: decrement and write cnt = 5 to loop 0 while it is selected with cnt = 2 -> cnt[0] = 5 next cycle.
- Decrement with no active loop -> all counters stay 0 and there is no wrap to 0xFFFFFFFF.
- Assert `rst` mid-loop with cnt = 7 -> outputs go to 0 asynchronously. CSR reads of every field return 0.
